mac_cmd_issuer: RTL and testbench
=================================

MAC_CMD_ISSUER -- requirements
Module: mac_cmd_issuer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- op_wr  in  1  host pushes one operand pair.
- op_a  in  8  operand a for the pushed pair.
- op_b  in  8  operand b for the pushed pair.
- op_full  out  1  operand FIFO holds 16 entries.
- op_count  out  5  number of FIFO entries, 0..16.
- start  in  1  host request to run a dot product.
- len  in  5  number of pairs for the run, 1..16; sampled with start.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when result is valid.
- err  out  1  one-cycle pulse on rejected start or timeout.
- result  out  20  captured accumulator value.
- go  out  1  start strobe to the MAC accelerator.
- n_out  out  5  pair count to the accelerator.
- a_out  out  8  operand a streamed to the accelerator.
- b_out  out  8  operand b streamed to the accelerator.
- acc_clr_n  out  1  active-low clear to the accelerator control/datapath.
- eoc  in  1  end-of-computation from the accelerator; level, sticky until cleared.
- acc_in  in  20  accumulator value from the accelerator.

Function
REQ-003 The operand FIFO SHALL be 16 entries x 16 bits ({a,b}), first-in first-out, with a 4-bit read pointer and a 4-bit write pointer that wrap 15->0.
REQ-004 op_wr while op_full SHALL be ignored; count and contents unchanged.
REQ-005 A simultaneous push and pop SHALL leave op_count unchanged and keep FIFO order.
REQ-006 The FSM states SHALL be IDLE, GO, LOADN, STREAM, WAIT, CAPTURE, CLEAR.
REQ-007 IDLE: start with 1<=len<=op_count SHALL latch len into n_out and move to GO.
- start with len=0 or len>op_count SHALL pulse err for one cycle and stay in IDLE.
- start outside IDLE SHALL be ignored.
REQ-008 GO SHALL drive go=1 for exactly one cycle, then move to LOADN.
REQ-009 LOADN SHALL last one cycle, aligned with the accelerator's N load, then move to STREAM.
REQ-010 STREAM SHALL pop one FIFO entry per cycle onto a_out/b_out (registered) for exactly n_out cycles.
- The first pair SHALL be valid in the cycle after LOADN.
- A 5-bit down-counter SHALL track the pops; STREAM SHALL move to WAIT when the counter reaches 0.
REQ-011 WAIT SHALL run a 6-bit timeout counter from 0.
- eoc=1 SHALL move the FSM to CAPTURE.
- A count of 63 without eoc SHALL pulse err, leave result unchanged, and move to CLEAR.
REQ-012 CAPTURE SHALL register acc_in into result, pulse done for that cycle, and move to CLEAR.
REQ-013 CLEAR SHALL drive acc_clr_n=0 for exactly 2 cycles, then return to IDLE.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 n_out SHALL stay stable from GO through CLEAR.
REQ-016 a_out/b_out SHALL hold their last value outside STREAM.
REQ-017 go SHALL never be asserted while eoc=1.
- If eoc=1 in IDLE, a start SHALL go to CLEAR first, then GO.
REQ-018 Host pushes during STREAM SHALL be accepted, and popped entries SHALL free space in the same cycle.
REQ-019 Latency SHALL be: start accepted -> go next cycle -> first operand at go+2 -> last operand at go+1+len.

Reset
REQ-020 While rst_n=0, the block SHALL set:
- state=IDLE
- FIFO pointers and count = 0, op_full=0
- go=0, done=0, err=0, busy=0
- result=0, n_out=0, a_out=0, b_out=0
- acc_clr_n=0
REQ-021 After reset release, acc_clr_n SHALL return to 1 on the first clock edge.
REQ-022 Assertion of rst_n mid-run SHALL abort the run immediately, discard FIFO contents, and produce no done pulse.

Verification
REQ-023 Push (1,2),(3,4),(5,6); start len=3 -> go one cycle later; a_out/b_out = 1/2, 3/4, 5/6 on consecutive cycles from go+2; model eoc with acc_in=44 -> result=44, done pulse, acc_clr_n low 2 cycles, busy falls.
REQ-024 Push 16 pairs -> op_full=1; 17th push ignored; start len=16 -> all 16 pairs streamed in order, pointers wrap, op_count=0 at end.
REQ-025 op_count=2, start len=3 -> err pulse, no go, busy=0; start len=0 -> err pulse.
REQ-026 Run with eoc held 0 -> err pulse 64 cycles after entering WAIT, result unchanged, CLEAR, IDLE.
REQ-027 Push on every STREAM cycle of a len=4 run -> op_count returns to its pre-run value; next run streams the new pairs in order.
REQ-028 Reset asserted during STREAM -> all outputs at reset values asynchronously, no done; next run behaves as after power-up.

Source files
------------

// File: rtl/mac_cmd_issuer.sv
// Command issuer for a MAC accelerator: buffers operand pairs in a 16-deep FIFO,
// sequences go / N-load / operand streaming / result capture / accelerator clear.
//
// state   | meaning
// IDLE    | waiting for a valid start
// GO      | one-cycle go strobe to the accelerator
// LOADN   | accelerator loads N; first pair popped onto a_out/b_out
// STREAM  | one operand pair presented per cycle, n_out cycles total
// WAIT    | waiting for eoc with a 63-cycle timeout
// CAPTURE | acc_in captured into result, done pulsed
// CLEAR   | acc_clr_n held low for two cycles
module mac_cmd_issuer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_wr,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic        op_full,
  output logic [4:0]  op_count,
  input  logic        start,
  input  logic [4:0]  len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [19:0] result,
  output logic        go,
  output logic [4:0]  n_out,
  output logic [7:0]  a_out,
  output logic [7:0]  b_out,
  output logic        acc_clr_n,
  input  logic        eoc,
  input  logic [19:0] acc_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_GO, S_LOADN, S_STREAM, S_WAIT, S_CAPTURE, S_CLEAR
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_mem [16];
  logic [3:0]  r_rd_ptr, r_wr_ptr;
  logic [4:0]  r_count;
  logic [4:0]  r_pop_cnt;
  logic [5:0]  r_tmo;
  logic        r_clr_cnt;
  logic        r_pending;
  logic        r_err;
  logic        r_acc_clr_n;
  logic [19:0] r_result;
  logic [4:0]  r_n;
  logic [7:0]  r_a, r_b;

  logic w_push, w_pop, w_len_ok, w_start_ok, w_start_bad, w_timeout;

  // Pops run one edge ahead of STREAM so the registered pair is valid in the first STREAM cycle.
  assign w_pop       = (r_state == S_LOADN) || ((r_state == S_STREAM) && (r_pop_cnt != 5'd0));
  assign w_push      = op_wr && ((r_count != 5'd16) || w_pop);
  assign w_len_ok    = (len != 5'd0) && (len <= r_count);
  assign w_start_ok  = (r_state == S_IDLE) && start && w_len_ok;
  assign w_start_bad = (r_state == S_IDLE) && start && !w_len_ok;
  assign w_timeout   = (r_state == S_WAIT) && !eoc && (r_tmo == 6'd63);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_start_ok) w_state_nxt = eoc ? S_CLEAR : S_GO;
      S_GO:      w_state_nxt = S_LOADN;
      S_LOADN:   w_state_nxt = S_STREAM;
      S_STREAM:  if (r_pop_cnt == 5'd0) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (eoc)            w_state_nxt = S_CAPTURE;
        else if (w_timeout) w_state_nxt = S_CLEAR;
      end
      S_CAPTURE: w_state_nxt = S_CLEAR;
      S_CLEAR: begin
        // A start deferred by a stale eoc keeps clearing until eoc drops.
        if (r_clr_cnt) begin
          if (!r_pending) w_state_nxt = S_IDLE;
          else if (!eoc)  w_state_nxt = S_GO;
        end
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {op_a, op_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr    <= 4'd0;
      r_wr_ptr    <= 4'd0;
      r_count     <= 5'd0;
      r_a         <= 8'd0;
      r_b         <= 8'd0;
      r_n         <= 5'd0;
      r_pop_cnt   <= 5'd0;
      r_tmo       <= 6'd0;
      r_clr_cnt   <= 1'b0;
      r_pending   <= 1'b0;
      r_err       <= 1'b0;
      r_acc_clr_n <= 1'b0;
      r_result    <= 20'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 4'd1;
      if (w_pop) begin
        {r_a, r_b} <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + 4'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase

      if (w_start_ok) r_n <= len;

      if (r_state == S_LOADN)                           r_pop_cnt <= r_n - 5'd1;
      else if (r_state == S_STREAM && r_pop_cnt != 5'd0) r_pop_cnt <= r_pop_cnt - 5'd1;

      r_tmo     <= (r_state == S_WAIT) ? r_tmo + 6'd1 : 6'd0;
      r_clr_cnt <= (r_state == S_CLEAR) ? ~r_clr_cnt : 1'b0;

      if (w_start_ok)              r_pending <= eoc;
      else if (w_state_nxt == S_GO) r_pending <= 1'b0;

      if (r_state == S_WAIT && eoc) r_result <= acc_in;

      r_err       <= w_start_bad || w_timeout;
      r_acc_clr_n <= (w_state_nxt != S_CLEAR);
    end
  end

  assign op_full   = (r_count == 5'd16);
  assign op_count  = r_count;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_CAPTURE);
  assign go        = (r_state == S_GO);
  assign err       = r_err;
  assign result    = r_result;
  assign n_out     = r_n;
  assign a_out     = r_a;
  assign b_out     = r_b;
  assign acc_clr_n = r_acc_clr_n;

endmodule

// File: tb/tb_mac_cmd_issuer.sv
// Directed bench for mac_cmd_issuer: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_mac_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_wr = 1'b0;
  logic [7:0]  op_a = 8'd0;
  logic [7:0]  op_b = 8'd0;
  logic        op_full;
  logic [4:0]  op_count;
  logic        start = 1'b0;
  logic [4:0]  len = 5'd0;
  logic        busy, done, err, go, acc_clr_n;
  logic [19:0] result;
  logic [4:0]  n_out;
  logic [7:0]  a_out, b_out;
  logic        eoc = 1'b0;
  logic [19:0] acc_in = 20'd0;

  int checks = 0;
  int errors = 0;

  mac_cmd_issuer dut (
    .clk(clk), .rst_n(rst_n), .op_wr(op_wr), .op_a(op_a), .op_b(op_b),
    .op_full(op_full), .op_count(op_count), .start(start), .len(len),
    .busy(busy), .done(done), .err(err), .result(result), .go(go),
    .n_out(n_out), .a_out(a_out), .b_out(b_out), .acc_clr_n(acc_clr_n),
    .eoc(eoc), .acc_in(acc_in)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    op_wr = 1'b1;
    op_a  = a;
    op_b  = b;
    step();
    op_wr = 1'b0;
  endtask

  initial begin
    // power-up reset
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_go", go, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    chk("rst_n_out", n_out, 0);
    chk("rst_ab", {a_out, b_out}, 0);
    chk("rst_clr_n", acc_clr_n, 0);
    chk("rst_count", op_count, 0);
    chk("rst_full", op_full, 0);
    rst_n = 1'b1;
    step();
    chk("rel_clr_n", acc_clr_n, 1);

    // basic 3-pair run
    push(8'd1, 8'd2);
    push(8'd3, 8'd4);
    push(8'd5, 8'd6);
    chk("a_count3", op_count, 3);
    start = 1'b1; len = 5'd3;
    step();
    start = 1'b0;
    chk("a_go", go, 1);
    chk("a_busy", busy, 1);
    chk("a_n_out", n_out, 3);
    step();
    chk("a_go_off", go, 0);
    step();
    chk("a_p0", {a_out, b_out}, 16'h0102);
    step();
    chk("a_p1", {a_out, b_out}, 16'h0304);
    step();
    chk("a_p2", {a_out, b_out}, 16'h0506);
    chk("a_count0", op_count, 0);
    step();
    chk("a_hold", {a_out, b_out}, 16'h0506);
    chk("a_wait_done", done, 0);
    eoc = 1'b1; acc_in = 20'd44;
    step();
    chk("a_done", done, 1);
    chk("a_result", result, 44);
    eoc = 1'b0;
    step();
    chk("a_done_off", done, 0);
    chk("a_clr1", acc_clr_n, 0);
    chk("a_n_stable", n_out, 3);
    step();
    chk("a_clr2", acc_clr_n, 0);
    chk("a_busy_clr", busy, 1);
    step();
    chk("a_clr_rel", acc_clr_n, 1);
    chk("a_idle", busy, 0);

    // rejected starts
    push(8'h10, 8'h80);
    push(8'h11, 8'h81);
    start = 1'b1; len = 5'd3;
    step();
    start = 1'b0;
    chk("b_err_long", err, 1);
    chk("b_no_go", go, 0);
    chk("b_busy", busy, 0);
    step();
    chk("b_err_off", err, 0);
    start = 1'b1; len = 5'd0;
    step();
    start = 1'b0;
    chk("b_err_zero", err, 1);
    chk("b_count", op_count, 2);

    // fill to 16, overflow push ignored, full-length run with pointer wrap
    for (int k = 2; k < 16; k++) push(8'h10 + 8'(k), 8'h80 + 8'(k));
    chk("c_full", op_full, 1);
    chk("c_count16", op_count, 16);
    push(8'hFF, 8'hFF);
    chk("c_ovf_count", op_count, 16);
    start = 1'b1; len = 5'd16;
    step();
    start = 1'b0;
    chk("c_go", go, 1);
    step();
    for (int k = 0; k < 16; k++) begin
      step();
      chk($sformatf("c_p%0d", k), {a_out, b_out}, {8'h10 + 8'(k), 8'h80 + 8'(k)});
    end
    chk("c_count0", op_count, 0);
    chk("c_not_full", op_full, 0);
    step();

    // eoc never arrives: timeout
    for (int i = 0; i < 63; i++) step();
    chk("d_no_err_63", err, 0);
    chk("d_busy", busy, 1);
    step();
    chk("d_err_64", err, 1);
    chk("d_result_kept", result, 44);
    chk("d_clr", acc_clr_n, 0);
    chk("d_no_done", done, 0);
    step();
    chk("d_err_off", err, 0);
    step();
    chk("d_idle", busy, 0);

    // pushes on every STREAM cycle
    for (int k = 0; k < 4; k++) push(8'h20 + 8'(k), 8'h30 + 8'(k));
    start = 1'b1; len = 5'd4;
    step();
    start = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("e_p%0d", k), {a_out, b_out}, {8'h20 + 8'(k), 8'h30 + 8'(k)});
      op_wr = 1'b1; op_a = 8'h40 + 8'(k); op_b = 8'h50 + 8'(k);
    end
    step();
    op_wr = 1'b0;
    chk("e_count_back", op_count, 4);
    eoc = 1'b1; acc_in = 20'h12345;
    step();
    chk("e_result", result, 20'h12345);
    eoc = 1'b0;
    step(); step(); step();
    chk("e_idle", busy, 0);

    // start while eoc still high: clear first, then go
    eoc = 1'b1;
    start = 1'b1; len = 5'd4;
    step();
    start = 1'b0;
    chk("f_clear_first", acc_clr_n, 0);
    chk("f_no_go", go, 0);
    chk("f_busy", busy, 1);
    eoc = 1'b0;
    step();
    chk("f_no_go2", go, 0);
    step();
    chk("f_go", go, 1);
    chk("f_n_out", n_out, 4);
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("f_p%0d", k), {a_out, b_out}, {8'h40 + 8'(k), 8'h50 + 8'(k)});
    end
    step();
    eoc = 1'b1; acc_in = 20'd7;
    step();
    chk("f_done", done, 1);
    chk("f_result", result, 7);
    eoc = 1'b0;
    step(); step(); step();
    chk("f_idle", busy, 0);

    // reset in the middle of STREAM
    push(8'hA1, 8'hB1);
    push(8'hA2, 8'hB2);
    push(8'hA3, 8'hB3);
    start = 1'b1; len = 5'd3;
    step();
    start = 1'b0;
    step();
    step();
    chk("g_stream", {a_out, b_out}, 16'hA1B1);
    #2 rst_n = 1'b0;
    #1;
    chk("g_busy", busy, 0);
    chk("g_ab", {a_out, b_out}, 0);
    chk("g_n_out", n_out, 0);
    chk("g_count", op_count, 0);
    chk("g_clr_n", acc_clr_n, 0);
    chk("g_result", result, 0);
    step();
    chk("g_no_done", done, 0);
    rst_n = 1'b1;
    step();
    chk("g_clr_rel", acc_clr_n, 1);
    push(8'h01, 8'h02);
    chk("g_count1", op_count, 1);
    start = 1'b1; len = 5'd1;
    step();
    start = 1'b0;
    chk("g_go", go, 1);
    step();
    step();
    chk("g_p0", {a_out, b_out}, 16'h0102);
    step();
    eoc = 1'b1; acc_in = 20'd99;
    step();
    chk("g_done", done, 1);
    chk("g_result99", result, 99);
    eoc = 1'b0;
    step(); step(); step();
    chk("g_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
